mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter WAIT_STATES, default 2, meaning idle cycles inserted between request acceptance and response (legal 0..15).
REQ-002 SHALL provide parameter PROT_BASE, default 8'hC0, meaning the lowest write-protected (read-only) address.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and res.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 res  input  1  synchronous active-high reset.
REQ-006 req  input  1  transaction request from the CPU control unit, level-sampled.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  8  byte address, driven from the CPU memory address register.
REQ-009 wdata  input  8  write data, driven from the CPU memory data register.
REQ-010 rdata  output  8  read data, registered, feeds the CPU memory data register input.
REQ-011 ack  output  1  one-cycle response strobe.
REQ-012 err  output  1  write-protect violation, valid only while ack=1.
REQ-013 busy  output  1  high while a transaction is in flight.

Function
REQ-014 SHALL contain 256 x 8 storage, indexed by the full 8-bit address, so every address is in range.
REQ-015 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-016 IDLE: req=1 at the edge latches addr, we and wdata into internal registers; the next state is WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT: a 4-bit down-counter loaded with WAIT_STATES-1 on entry; leave for RESP at the edge where the counter equals 0.
REQ-018 Storage write and rdata load SHALL occur at the edge entering RESP.
REQ-019 RESP lasts exactly one cycle.
REQ-020 ack=1 only in RESP.
REQ-021 ack SHALL rise exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-022 Read: rdata takes the value of the latched address's storage location.
REQ-023 Read: rdata holds until the next completed read or reset.
REQ-024 Write with latched addr < PROT_BASE: storage location updated with latched wdata; rdata unchanged; err=0.
REQ-025 Write with latched addr >= PROT_BASE: storage unchanged; err=1 during RESP; rdata unchanged.
REQ-026 Read of a protected address SHALL succeed with err=0.
REQ-027 RESP with req=1: accept the new request (back-to-back), with the same transitions as IDLE.
REQ-028 RESP with req=0: return to IDLE.
REQ-029 req in WAIT SHALL be ignored: no queuing, no latch update, no effect on the current transaction.
REQ-030 Input changes on addr, we or wdata after the accepting edge SHALL NOT affect the in-flight transaction.
REQ-031 busy = 1 in WAIT and RESP, 0 in IDLE; registered, no combinational path from req.
REQ-032 Read-after-write to the same address SHALL return the written value with no extra hazard cycles.
REQ-033 A WAIT_STATES value above 15 is illegal; behaviour is undefined and the bench flags it at elaboration.

Reset
REQ-034 res=1 at an edge: FSM to IDLE; counter 0; rdata=8'h00; ack=0; err=0; busy=0; all 256 locations cleared to 8'h00.
REQ-035 Reset SHALL override any in-flight transaction; a pending write is dropped and no ack is issued.
REQ-036 res has priority over req in the same cycle.

Verification (WAIT_STATES=2, PROT_BASE=8'hC0 unless stated)
REQ-037 Write then read: write 8'h5A to 8'h10, then read 8'h10 -> each ack exactly 3 cycles after acceptance; rdata=8'h5A; err=0.
REQ-038 Protected write: write 8'hFF to 8'hC0 -> ack with err=1; subsequent read of 8'hC0 returns 8'h00.
REQ-039 Boundary write: write 8'h33 to 8'hBF -> err=0; read-back returns 8'h33.
REQ-040 Back-to-back: hold req=1 across RESP with reads of 8'h01 then 8'h02 -> second transaction accepted in the RESP cycle; acks 3 cycles apart; req pulses during WAIT ignored.
REQ-041 Reset mid-write: res asserted in WAIT of a write of 8'hAA to 8'h20 -> no ack; busy=0 next cycle; read of 8'h20 returns 8'h00.
REQ-042 WAIT_STATES=0: ack in the cycle right after acceptance; continuous req yields ack every cycle.

Source files
------------

// File: rtl/mem_responder.sv
// 256x8 memory responder with fixed wait-state latency and a read-only
// upper region; one transaction in flight, back-to-back accept in RESP.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  PROT_BASE   = 8'hC0
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [7:0]  mem_q [256];

  logic        accept;
  logic        direct;
  logic        op_we;
  logic [7:0]  op_addr;
  logic [7:0]  op_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge itself,
  // so the operation must come straight from the ports.
  always_comb begin
    direct   = (state_q != WAIT);
    op_we    = direct ? we    : we_q;
    op_addr  = direct ? addr  : addr_q;
    op_wdata = direct ? wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_d == RESP) begin
        if (op_we) begin
          if (op_addr < PROT_BASE) begin
            mem_q[op_addr] <= op_wdata;
          end
        end else begin
          rdata_q <= mem_q[op_addr];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign err   = ack && we_q && (addr_q >= PROT_BASE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_mem_responder;

  localparam int unsigned WS = 2;

  logic       clk;
  logic       res;
  logic       req, we;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       ack, err, busy;

  logic       zreq, zwe;
  logic [7:0] zaddr, zwdata;
  logic [7:0] zrdata;
  logic       zack, zerr, zbusy;

  int checks;
  int failures;

  mem_responder #(
    .WAIT_STATES(WS),
    .PROT_BASE  (8'hC0)
  ) dut (
    .clk  (clk),
    .res  (res),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ack  (ack),
    .err  (err),
    .busy (busy)
  );

  mem_responder #(
    .WAIT_STATES(0),
    .PROT_BASE  (8'hC0)
  ) dut0 (
    .clk  (clk),
    .res  (res),
    .req  (zreq),
    .we   (zwe),
    .addr (zaddr),
    .wdata(zwdata),
    .rdata(zrdata),
    .ack  (zack),
    .err  (zerr),
    .busy (zbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request cycle, then scrambled inputs; returns cycles to ack.
  task automatic xact(input logic w, input logic [7:0] a,
                      input logic [7:0] d, output int lat,
                      output logic e, output logic [7:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    lat = 1;
    while (!ack && lat < 20) begin
      step();
      lat++;
    end
    e  = err;
    rd = rdata;
    step();
  endtask

  int         lat;
  logic       e;
  logic [7:0] rd;

  initial begin
    checks   = 0;
    failures = 0;
    if (WS > 15) $fatal(1, "WAIT_STATES out of range: %0d", WS);
    res = 1'b1;
    req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
    zreq = 1'b0; zwe = 1'b0; zaddr = 8'h00; zwdata = 8'h00;
    step();
    step();
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    res = 1'b0;
    step();

    req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'h5A;
    step();
    req = 1'b0; addr = 8'hEE; wdata = 8'h00; we = 1'b0;
    chk("busy_wait", busy, 1'b1);
    chk("ack_wait", ack, 1'b0);
    step();
    chk("ack_wait2", ack, 1'b0);
    step();
    chk("wr10_ack", ack, 1'b1);
    chk("wr10_err", err, 1'b0);
    step();
    chk("idle_busy", busy, 1'b0);

    xact(1'b0, 8'h10, 8'h00, lat, e, rd);
    chk("rd10_lat", lat, 3);
    chk("rd10_data", rd, 8'h5A);
    chk("rd10_err", e, 1'b0);

    xact(1'b1, 8'hC0, 8'hFF, lat, e, rd);
    chk("wrC0_lat", lat, 3);
    chk("wrC0_err", e, 1'b1);
    chk("wrC0_rdata_hold", rd, 8'h5A);
    xact(1'b0, 8'hC0, 8'h00, lat, e, rd);
    chk("rdC0_data", rd, 8'h00);
    chk("rdC0_err", e, 1'b0);

    xact(1'b1, 8'hBF, 8'h33, lat, e, rd);
    chk("wrBF_err", e, 1'b0);
    xact(1'b0, 8'hBF, 8'h00, lat, e, rd);
    chk("rdBF_data", rd, 8'h33);
    xact(1'b1, 8'h11, 8'h77, lat, e, rd);
    chk("wr11_rdata_hold", rd, 8'h33);

    xact(1'b1, 8'h01, 8'h11, lat, e, rd);
    xact(1'b1, 8'h02, 8'h22, lat, e, rd);
    req = 1'b1; we = 1'b0; addr = 8'h01;
    step();
    req = 1'b1; addr = 8'h55;
    step();
    req = 1'b0; addr = 8'h66;
    step();
    chk("b2b_ack1", ack, 1'b1);
    chk("b2b_rd1", rdata, 8'h11);
    req = 1'b1; addr = 8'h02;
    step();
    req = 1'b0; addr = 8'h77;
    chk("b2b_gap1", ack, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    step();
    chk("b2b_gap2", ack, 1'b0);
    step();
    chk("b2b_ack2", ack, 1'b1);
    chk("b2b_rd2", rdata, 8'h22);
    step();
    chk("b2b_idle", busy, 1'b0);

    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'hAA;
    step();
    req = 1'b0; res = 1'b1;
    step();
    res = 1'b0;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ack", ack, 1'b0);
    chk("rstmid_rdata", rdata, 8'h00);
    step();
    chk("rstmid_ack2", ack, 1'b0);
    step();
    chk("rstmid_ack3", ack, 1'b0);
    xact(1'b0, 8'h20, 8'h00, lat, e, rd);
    chk("rd20_data", rd, 8'h00);
    chk("rd20_lat", lat, 3);

    req = 1'b1; we = 1'b0; addr = 8'h01; res = 1'b1;
    step();
    req = 1'b0; res = 1'b0;
    chk("res_prio_busy", busy, 1'b0);
    step();
    chk("res_prio_ack", ack, 1'b0);

    zreq = 1'b1; zwe = 1'b1; zaddr = 8'h40; zwdata = 8'h9C;
    step();
    chk("z_wr_ack", zack, 1'b1);
    chk("z_wr_err", zerr, 1'b0);
    zwe = 1'b0; zwdata = 8'h00;
    step();
    chk("z_rd_ack", zack, 1'b1);
    chk("z_rd_data", zrdata, 8'h9C);
    zwe = 1'b1; zaddr = 8'hC5; zwdata = 8'h12;
    step();
    chk("z_prot_ack", zack, 1'b1);
    chk("z_prot_err", zerr, 1'b1);
    zwe = 1'b0;
    step();
    chk("z_rdC5_data", zrdata, 8'h00);
    zreq = 1'b0;
    step();
    chk("z_idle_ack", zack, 1'b0);
    chk("z_idle_busy", zbusy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
